wb_mem_arb: RTL
===============

WB_MEM_ARB -- requirements
Module: wb_mem_arb

Interface
REQ-001 SHALL have parameter PREFETCH_EN, default 1, meaning 1 = next-word instruction prefetch enabled, 0 = plain arbiter.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports wb_imem_stb_i in 1, wb_imem_adr_i in 32 (byte address), wb_imem_ack_o out 1, wb_imem_dat_o out 32; this is the instruction Wishbone port, read-only.
REQ-005 SHALL have ports wb_dmem_stb_i in 1, wb_dmem_we_i in 1, wb_dmem_be_i in 4, wb_dmem_adr_i in 32 (byte address), wb_dmem_dat_i in 32, wb_dmem_ack_o out 1, wb_dmem_dat_o out 32; this is the data Wishbone port.
REQ-006 SHALL have ports wb_mem_stb_o out 1, wb_mem_we_o out 1, wb_mem_be_o out 4, wb_mem_adr_o out 22 (word address), wb_mem_dat_o out 32, wb_mem_ack_i in 1, wb_mem_dat_i in 32; this is the downstream port to the QSPI memory controller.
REQ-007 SHALL have port sel_rom_ram_o  output  1  downstream device select, 0 = flash ROM, 1 = QSPI RAM.

Function
REQ-008 SHALL decode every request: byte-address bit 24 drives sel_rom_ram_o; byte-address bits [23:2] drive wb_mem_adr_o; bits [31:25] and [1:0] are ignored.
REQ-009 SHALL implement FSM states IDLE, DATA, INSTR, PREF, HIT; the state register, sel_rom_ram_o and the wb_mem_* outputs SHALL all be registered.
REQ-010 SHALL, in IDLE, give priority data > instruction hit > instruction miss > prefetch.
REQ-011 SHALL, in IDLE, handle wb_dmem_stb_i as follows: latch we/be/adr/dat, assert wb_mem_stb_o from the next cycle, go to DATA.
REQ-012 SHALL, in IDLE, handle wb_imem_stb_i when the buffer holds that address as follows: go to HIT, then assert wb_imem_ack_o for exactly one cycle with the buffer data; hit latency is 1 cycle after stb is sampled.
REQ-013 SHALL, in IDLE, handle wb_imem_stb_i on a miss as follows: issue a downstream read (we=0, be=4'hF), go to INSTR.
REQ-014 SHALL keep wb_mem_stb_o and all wb_mem_* fields stable from issue until the cycle wb_mem_ack_i is sampled high; a downstream transfer is never aborted or altered.
REQ-015 SHALL, in DATA/INSTR, drive the owning port's ack in the same cycle as wb_mem_ack_i and pass wb_mem_dat_i through to that port's dat_o; stb_o is deasserted next cycle and the FSM returns to IDLE.
REQ-016 SHALL, with PREFETCH_EN=1 and after an INSTR completion at word W, enter PREF next if wb_dmem_stb_i=0, W != 22'h3FFFFF and the buffer does not already hold W+1 with the same select; PREF issues a read of W+1 with the same sel_rom_ram_o.
REQ-017 SHALL, on PREF completion, load buffer {valid=1, sel, tag=W+1, data}; if wb_imem_stb_i is high with a matching address in that cycle, SHALL also ack it in that cycle with wb_mem_dat_i (merge).
REQ-018 SHALL, when the buffer serves a hit, immediately prefetch the following word (REQ-016 rules with W = hit word); requests arriving during PREF wait until it completes.
REQ-019 SHALL, on any data write (either select) whose word address equals the buffer tag, clear valid in the issue cycle; writes alias ROM/RAM, so the select is not compared.
REQ-020 SHALL never assert both upstream acks in one cycle, and SHALL assert no ack without a pending stb.
REQ-021 SHALL, with PREFETCH_EN=0, never enter PREF/HIT and keep valid=0.

Reset
REQ-022 SHALL, while rst_i is high at a clock edge, set state IDLE, valid 0, wb_mem_stb_o 0, wb_mem_we_o 0, wb_mem_be_o 0, wb_mem_adr_o 0, wb_mem_dat_o 0, sel_rom_ram_o 0, both acks 0, both dat_o 0.
REQ-023 SHALL handle reset mid-transfer by dropping wb_mem_stb_o the next cycle and ignoring any later wb_mem_ack_i until a new issue.

Verification
REQ-024 SHALL be covered by: imem read 0x0000_0100 (miss), downstream acks after 20 cycles with 0xDEADBEEF -> wb_mem_adr_o=0x40, sel=0, imem ack with 0xDEADBEEF same cycle, then PREF read of 0x41.
REQ-025 SHALL be covered by: after the PREF completes, imem read 0x0000_0104 -> ack 1 cycle later with no downstream stb for it, then PREF of 0x42.
REQ-026 SHALL be covered by: imem and dmem stb in the same cycle in IDLE -> dmem issued first; imem served after dmem ack; never two acks in one cycle.
REQ-027 SHALL be covered by: buffer valid for tag 0x41; dmem write be=4'b0010 to 0x0100_0104 -> valid cleared; next imem 0x0000_0104 goes downstream.
REQ-028 SHALL be covered by: imem 0x0000_0108 arriving during PREF of 0x42 -> acked in the PREF completion cycle with wb_mem_dat_i.
REQ-029 SHALL be covered by: rst_i pulsed 1 cycle while wb_mem_stb_o=1 -> stb_o=0 the next cycle; a stale wb_mem_ack_i produces no upstream ack; imem fetch of 0x00FF_FFFC issues no prefetch.

Source files
------------

// File: rtl/wb_mem_arb_if.sv
// Bus bundle for wb_mem_arb: instruction port, data port and the downstream
// port towards the QSPI memory controller.
// The slave modport is the arbiter's own view. The master modport is the view
// of everything around it (CPU and memory controller).
interface wb_mem_arb_if;
  logic        wb_imem_stb_i;
  logic [31:0] wb_imem_adr_i;
  logic        wb_imem_ack_o;
  logic [31:0] wb_imem_dat_o;

  logic        wb_dmem_stb_i;
  logic        wb_dmem_we_i;
  logic [3:0]  wb_dmem_be_i;
  logic [31:0] wb_dmem_adr_i;
  logic [31:0] wb_dmem_dat_i;
  logic        wb_dmem_ack_o;
  logic [31:0] wb_dmem_dat_o;

  logic        wb_mem_stb_o;
  logic        wb_mem_we_o;
  logic [3:0]  wb_mem_be_o;
  logic [21:0] wb_mem_adr_o;
  logic [31:0] wb_mem_dat_o;
  logic        wb_mem_ack_i;
  logic [31:0] wb_mem_dat_i;
  logic        sel_rom_ram_o;

  modport slave (
    input  wb_imem_stb_i, wb_imem_adr_i,
    output wb_imem_ack_o, wb_imem_dat_o,
    input  wb_dmem_stb_i, wb_dmem_we_i, wb_dmem_be_i, wb_dmem_adr_i, wb_dmem_dat_i,
    output wb_dmem_ack_o, wb_dmem_dat_o,
    output wb_mem_stb_o, wb_mem_we_o, wb_mem_be_o, wb_mem_adr_o, wb_mem_dat_o, sel_rom_ram_o,
    input  wb_mem_ack_i, wb_mem_dat_i
  );

  modport master (
    output wb_imem_stb_i, wb_imem_adr_i,
    input  wb_imem_ack_o, wb_imem_dat_o,
    output wb_dmem_stb_i, wb_dmem_we_i, wb_dmem_be_i, wb_dmem_adr_i, wb_dmem_dat_i,
    input  wb_dmem_ack_o, wb_dmem_dat_o,
    input  wb_mem_stb_o, wb_mem_we_o, wb_mem_be_o, wb_mem_adr_o, wb_mem_dat_o, sel_rom_ram_o,
    output wb_mem_ack_i, wb_mem_dat_i
  );
endinterface

// File: rtl/wb_mem_arb.sv
// Arbiter between the instruction and data Wishbone ports and one QSPI memory
// controller. It has a one-word instruction prefetch buffer.
// Data requests win over instruction requests. An instruction fetch that hits
// the buffer is answered without going downstream. After each instruction
// fetch the following word is read into the buffer in the background.
module wb_mem_arb #(
  parameter int PREFETCH_EN = 1
) (
  input logic        clk_i,
  input logic        rst_i,
  wb_mem_arb_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DATA, INSTR, PREF, HIT} state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_memStb;
  logic        r_memWe;
  logic [3:0]  r_memBe;
  logic [21:0] r_memAdr;
  logic [31:0] r_memDat;
  logic        r_sel;

  logic        r_bufValid;
  logic        r_bufSel;
  logic [21:0] r_bufTag;
  logic [31:0] r_bufData;

  logic [21:0] w_iWord;
  logic        w_iSel;
  logic [21:0] w_dWord;
  logic        w_dSel;
  logic        w_hit;
  logic        w_memDone;
  logic [21:0] w_pfBase;
  logic        w_pfSel;
  logic [21:0] w_pfWord;
  logic        w_pfOk;
  logic        w_prefMatch;
  logic        w_imemAck;
  logic [31:0] w_imemDat;
  logic        w_dmemAck;
  logic [31:0] w_dmemDat;
  logic        w_unusedBits;

  // Upper byte-address bits and the byte offset play no part in decoding.
  assign w_unusedBits = ^{bus.wb_imem_adr_i[31:25], bus.wb_imem_adr_i[1:0],
                          bus.wb_dmem_adr_i[31:25], bus.wb_dmem_adr_i[1:0]};

  assign w_iWord   = bus.wb_imem_adr_i[23:2];
  assign w_iSel    = bus.wb_imem_adr_i[24];
  assign w_dWord   = bus.wb_dmem_adr_i[23:2];
  assign w_dSel    = bus.wb_dmem_adr_i[24];
  assign w_hit     = (PREFETCH_EN != 0) && r_bufValid && (r_bufTag == w_iWord) && (r_bufSel == w_iSel);
  assign w_memDone = r_memStb && bus.wb_mem_ack_i;

  // Prefetch follows the word just served: the buffer tag after a hit, or
  // the word just fetched downstream after a miss.
  assign w_pfBase    = (r_state == HIT) ? r_bufTag : r_memAdr;
  assign w_pfSel     = (r_state == HIT) ? r_bufSel : r_sel;
  assign w_pfWord    = w_pfBase + 22'd1;
  assign w_pfOk      = (PREFETCH_EN != 0) && !bus.wb_dmem_stb_i && (w_pfBase != 22'h3FFFFF) &&
                       !(r_bufValid && (r_bufTag == w_pfWord) && (r_bufSel == w_pfSel));
  assign w_prefMatch = (w_iWord == r_memAdr) && (w_iSel == r_sel);

  assign bus.wb_imem_ack_o = w_imemAck;
  assign bus.wb_imem_dat_o = w_imemDat;
  assign bus.wb_dmem_ack_o = w_dmemAck;
  assign bus.wb_dmem_dat_o = w_dmemDat;
  assign bus.wb_mem_stb_o  = r_memStb;
  assign bus.wb_mem_we_o   = r_memWe;
  assign bus.wb_mem_be_o   = r_memBe;
  assign bus.wb_mem_adr_o  = r_memAdr;
  assign bus.wb_mem_dat_o  = r_memDat;
  assign bus.sel_rom_ram_o = r_sel;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next state and upstream acks. Each ack fires only for the port that owns the state, and only while that port still holds stb.
  always_comb begin
    w_nextState = r_state;
    w_imemAck   = 1'b0;
    w_imemDat   = '0;
    w_dmemAck   = 1'b0;
    w_dmemDat   = '0;
    case (r_state)
      IDLE: begin
        if (bus.wb_dmem_stb_i)              w_nextState = DATA;
        else if (bus.wb_imem_stb_i && w_hit) w_nextState = HIT;
        else if (bus.wb_imem_stb_i)          w_nextState = INSTR;
      end
      DATA: begin
        if (w_memDone) begin
          w_dmemAck   = bus.wb_dmem_stb_i;
          w_dmemDat   = bus.wb_dmem_stb_i ? bus.wb_mem_dat_i : 32'h0;
          w_nextState = IDLE;
        end
      end
      INSTR: begin
        if (w_memDone) begin
          w_imemAck   = bus.wb_imem_stb_i;
          w_imemDat   = bus.wb_imem_stb_i ? bus.wb_mem_dat_i : 32'h0;
          w_nextState = w_pfOk ? PREF : IDLE;
        end
      end
      PREF: begin
        if (w_memDone) begin
          if (bus.wb_imem_stb_i && w_prefMatch) begin
            w_imemAck = 1'b1;
            w_imemDat = bus.wb_mem_dat_i;
          end
          w_nextState = IDLE;
        end
      end
      HIT: begin
        w_imemAck   = bus.wb_imem_stb_i;
        w_imemDat   = bus.wb_imem_stb_i ? r_bufData : 32'h0;
        w_nextState = w_pfOk ? PREF : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    if (rst_i) begin
      w_imemAck = 1'b0;
      w_imemDat = '0;
      w_dmemAck = 1'b0;
      w_dmemDat = '0;
    end
  end

  // Downstream request registers and prefetch buffer. While stb is up the fields never change, and a prefetch always raises stb one cycle after entering PREF.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_memStb   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memBe    <= 4'h0;
      r_memAdr   <= '0;
      r_memDat   <= '0;
      r_sel      <= 1'b0;
      r_bufValid <= 1'b0;
      r_bufSel   <= 1'b0;
      r_bufTag   <= '0;
      r_bufData  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.wb_dmem_stb_i) begin
            r_memStb <= 1'b1;
            r_memWe  <= bus.wb_dmem_we_i;
            r_memBe  <= bus.wb_dmem_be_i;
            r_memAdr <= w_dWord;
            r_memDat <= bus.wb_dmem_dat_i;
            r_sel    <= w_dSel;
            if (bus.wb_dmem_we_i && (w_dWord == r_bufTag)) r_bufValid <= 1'b0;
          end else if (bus.wb_imem_stb_i && !w_hit) begin
            r_memStb <= 1'b1;
            r_memWe  <= 1'b0;
            r_memBe  <= 4'hF;
            r_memAdr <= w_iWord;
            r_memDat <= '0;
            r_sel    <= w_iSel;
          end
        end
        DATA: begin
          if (w_memDone) r_memStb <= 1'b0;
        end
        INSTR: begin
          if (w_memDone) begin
            r_memStb <= 1'b0;
            if (w_nextState == PREF) r_memAdr <= w_pfWord;
          end
        end
        PREF: begin
          if (!r_memStb) begin
            r_memStb <= 1'b1;
          end else if (w_memDone) begin
            r_memStb   <= 1'b0;
            r_bufValid <= 1'b1;
            r_bufSel   <= r_sel;
            r_bufTag   <= r_memAdr;
            r_bufData  <= bus.wb_mem_dat_i;
          end
        end
        HIT: begin
          if (w_nextState == PREF) begin
            r_memWe  <= 1'b0;
            r_memBe  <= 4'hF;
            r_memAdr <= w_pfWord;
            r_memDat <= '0;
            r_sel    <= r_bufSel;
          end
        end
        default: r_memStb <= 1'b0;
      endcase
    end
  end

endmodule
